// File: rtl/pwm_fade_ramp.sv
// pwm_fade_ramp
// Produces the 8-bit duty code for one PWM channel as a repeating
// "breathing" profile: ramp up, hold high, ramp down, hold low.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enable     1 = profile advances, 0 = everything frozen
//   restart    synchronous one-cycle pulse, restarts from the bottom of RISE
//   value      registered duty code to the PWM stage
//   phase      current state (0 RISE, 1 HOLD_HI, 2 FALL, 3 HOLD_LO); this is
//              the state register itself, so it doubles as the FSM debug view
//   cycle_done one-clock pulse on the HOLD_LO -> RISE transition
//
// Parameters:
//   STEP_DIV   clocks per step tick (2 .. 2^24-1)
//   STEP_SIZE  duty change per tick (1 .. 255)
//   HOLD_TICKS ticks spent in each hold state (1 .. 65535)
module pwm_fade_ramp #(
  parameter int unsigned STEP_DIV   = 46875,
  parameter int unsigned STEP_SIZE  = 1,
  parameter int unsigned HOLD_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       restart,
  output logic [7:0] value,
  output logic [1:0] phase,
  output logic       cycle_done
);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } state_t;

  localparam logic [23:0] PRE_LAST  = 24'(STEP_DIV - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
  localparam logic [8:0]  STEP      = 9'(STEP_SIZE);

  state_t      state_q, state_d;
  logic [23:0] pre_q, pre_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  value_q, value_d;
  logic        done_q, done_d;

  logic        tick;
  logic [8:0]  sum;
  logic [8:0]  diff;

  // The prescaler only moves while enabled, so tick is implicitly gated too.
  assign tick = enable && (pre_q == PRE_LAST);

  // Ninth bit catches overflow on the way up and borrow on the way down,
  // so the last step of a ramp clamps instead of wrapping the 8-bit code.
  assign sum  = {1'b0, value_q} + STEP;
  assign diff = {1'b0, value_q} - STEP;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    hold_d  = hold_q;
    value_d = value_q;
    done_d  = 1'b0;

    if (restart) begin
      // Wins over a coincident tick and acts regardless of enable.
      state_d = RISE;
      pre_d   = '0;
      hold_d  = '0;
      value_d = '0;
    end else if (enable) begin
      pre_d = tick ? 24'd0 : pre_q + 24'd1;
      if (tick) begin
        case (state_q)
          RISE: begin
            if (sum >= 9'd255) begin
              value_d = 8'hFF;
              state_d = HOLD_HI;
              hold_d  = '0;
            end else begin
              value_d = sum[7:0];
            end
          end
          HOLD_HI: begin
            if (hold_q == HOLD_LAST) state_d = FALL;
            else                     hold_d  = hold_q + 16'd1;
          end
          FALL: begin
            // diff[8] set means the subtraction borrowed (went below zero).
            if (diff[8] || (diff == 9'd0)) begin
              value_d = 8'h00;
              state_d = HOLD_LO;
              hold_d  = '0;
            end else begin
              value_d = diff[7:0];
            end
          end
          HOLD_LO: begin
            if (hold_q == HOLD_LAST) begin
              state_d = RISE;
              done_d  = 1'b1;
            end else begin
              hold_d = hold_q + 16'd1;
            end
          end
          default: state_d = RISE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RISE;
      pre_q   <= '0;
      hold_q  <= '0;
      value_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      value_q <= value_d;
      done_q  <= done_d;
    end
  end

  assign value      = value_q;
  assign phase      = state_q;
  assign cycle_done = done_q;

endmodule
